// File: rtl/exec_unit_if.sv
// Execute-stage bundle between the fde sequencer/RAM side (master) and exec_unit (slave).
// Optional EXEC_UNIT_FLAGS_EN adds the carry/zero status outputs.
interface exec_unit_if #(
  parameter int ADDRESS_BITS = 5,
  parameter int DATA_BITS    = 8
);
  logic                    enable;
  logic [2:0]              opcode;
  logic [ADDRESS_BITS-1:0] operand;
  logic [ADDRESS_BITS-1:0] mem_address;
  logic [DATA_BITS-1:0]    mem_rd_data;
  logic                    mem_wr_en;
  logic [DATA_BITS-1:0]    mem_wr_data;
  logic [DATA_BITS-1:0]    acc;
  logic                    busy;
  logic                    done;
  logic                    illegal;
`ifdef EXEC_UNIT_FLAGS_EN
  logic                    carry;
  logic                    zero;

  modport master (
    output enable, opcode, operand, mem_rd_data,
    input  mem_address, mem_wr_en, mem_wr_data, acc, busy, done, illegal, carry, zero
  );
  modport slave (
    input  enable, opcode, operand, mem_rd_data,
    output mem_address, mem_wr_en, mem_wr_data, acc, busy, done, illegal, carry, zero
  );
`else
  modport master (
    output enable, opcode, operand, mem_rd_data,
    input  mem_address, mem_wr_en, mem_wr_data, acc, busy, done, illegal
  );
  modport slave (
    input  enable, opcode, operand, mem_rd_data,
    output mem_address, mem_wr_en, mem_wr_data, acc, busy, done, illegal
  );
`endif
endinterface

// File: rtl/exec_unit.sv
// Accumulator execute stage: LD/ADD/STR/NOP against a synchronous RAM; EXEC_UNIT_FLAGS_EN adds carry/zero.
// Latency accept-to-done: 3 cycles LD/ADD, 2 STR, 1 NOP/illegal.
// No backpressure: enable is only sampled in IDLE; busy is high while an operation is in flight.
module exec_unit #(
  parameter int ADDRESS_BITS = 5,
  parameter int DATA_BITS    = 8
) (
  input  logic        clk,
  input  logic        reset,
  exec_unit_if.slave  bus
);

  typedef enum logic [2:0] {IDLE, FETCH_OP, LOAD, STORE, DONE} state_t;

  localparam logic [2:0] OP_NOP = 3'b000;
  localparam logic [2:0] OP_LD  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_STR = 3'b100;

  state_t                  state;
  state_t                  state_nxt;
  logic [2:0]              op_q;
  logic [ADDRESS_BITS-1:0] operand_q;
  logic [DATA_BITS-1:0]    acc_q;
  logic [DATA_BITS:0]      sum;
  logic [DATA_BITS-1:0]    acc_nxt;
  logic                    op_illegal;

  assign sum        = {1'b0, acc_q} + {1'b0, bus.mem_rd_data};
  assign acc_nxt    = (op_q == OP_ADD) ? sum[DATA_BITS-1:0] : bus.mem_rd_data;
  assign op_illegal = !(op_q == OP_NOP || op_q == OP_LD || op_q == OP_ADD || op_q == OP_STR);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      op_q      <= OP_NOP;
      operand_q <= '0;
      acc_q     <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && bus.enable) begin
        op_q      <= bus.opcode;
        operand_q <= bus.operand;
      end
      if (state == LOAD) begin
        acc_q <= acc_nxt;
      end
    end
  end

`ifdef EXEC_UNIT_FLAGS_EN
  logic carry_q;
  logic zero_q;

  // LD clears carry; both flags follow the value being written into acc.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
    end else if (state == LOAD) begin
      carry_q <= (op_q == OP_ADD) ? sum[DATA_BITS] : 1'b0;
      zero_q  <= (acc_nxt == '0);
    end
  end

  assign bus.carry = carry_q;
  assign bus.zero  = zero_q;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (bus.enable) begin
          if (bus.opcode == OP_LD || bus.opcode == OP_ADD) state_nxt = FETCH_OP;
          else if (bus.opcode == OP_STR)                   state_nxt = STORE;
          else                                             state_nxt = DONE;
        end
      end
      FETCH_OP: state_nxt = LOAD;
      LOAD:     state_nxt = DONE;
      STORE:    state_nxt = DONE;
      DONE:     state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // All outputs decode from state so an async reset clears them in the same cycle.
  always_comb begin
    bus.mem_address = '0;
    if (state == FETCH_OP || state == STORE) begin
      bus.mem_address = operand_q;
    end
  end

  assign bus.mem_wr_en   = (state == STORE);
  assign bus.mem_wr_data = acc_q;
  assign bus.acc         = acc_q;
  assign bus.busy        = (state != IDLE);
  assign bus.done        = (state == DONE);
  assign bus.illegal     = (state == DONE) && op_illegal;

endmodule

// File: doc/exec_unit.md
EXEC_UNIT -- requirements
Module: exec_unit

Interface
REQ-001 The block SHALL have parameter ADDRESS_BITS, default 5, meaning the RAM address width.
REQ-002 The block SHALL have parameter DATA_BITS, default 8, meaning the RAM data and accumulator width.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state changes on rising edge.
REQ-004 The block SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-005 The block SHALL have port enable, input, 1, the execute strobe from the fde sequencer.
REQ-006 The block SHALL have port opcode, input, 3, the decoded instruction from ctrl: 000 NOP, 001 LD, 010 ADD, 100 STR.
REQ-007 The block SHALL have port operand, input, ADDRESS_BITS, the decoded memory address from ctrl.
REQ-008 The block SHALL have port mem_address, output, ADDRESS_BITS, the execute-stage RAM address, feeding a mux4 input.
REQ-009 The block SHALL have port mem_rd_data, input, DATA_BITS, the RAM read data, valid one clock after the address is presented.
REQ-010 The block SHALL have port mem_wr_en, output, 1, the RAM write enable.
REQ-011 The block SHALL have port mem_wr_data, output, DATA_BITS, the RAM write data.
REQ-012 The block SHALL have port acc, output, DATA_BITS, the accumulator value.
REQ-013 The block SHALL have ports busy, done and illegal, output, 1 each: operation in progress, one-cycle completion pulse, and one-cycle bad-opcode pulse.

Function
REQ-014 The FSM SHALL have the states IDLE, FETCH_OP, LOAD, STORE and DONE.
REQ-015 In IDLE with enable=1, the block SHALL register opcode and operand and go to FETCH_OP (LD/ADD), STORE (STR) or DONE (NOP/other).
REQ-016 The block SHALL ignore enable in every state except IDLE; the registered opcode/operand SHALL stay stable until IDLE.
REQ-017 In FETCH_OP, mem_address SHALL equal the registered operand; next state LOAD.
REQ-018 In LOAD, the block SHALL set acc to mem_rd_data (LD) or to (acc + mem_rd_data) mod 2^DATA_BITS (ADD) at the clock edge; next state DONE.
REQ-019 In STORE, mem_wr_en=1, mem_address=operand, mem_wr_data=acc for exactly one cycle; next state DONE.
REQ-020 In DONE, done=1 for one cycle; next state IDLE; a new enable is accepted from IDLE only.
REQ-021 Latency from the accepting edge to done SHALL be 3 cycles for LD/ADD, 2 for STR and 1 for NOP/illegal.
REQ-022 Opcodes 011, 101, 110 and 111 SHALL make illegal=1 together with done, leave acc unchanged and perform no memory access.
REQ-023 Outside FETCH_OP/STORE, mem_address SHALL be 0; mem_wr_en=0 in every state except STORE; mem_wr_data SHALL equal acc at all times.
REQ-024 busy SHALL be 1 in every state except IDLE.

Reset
REQ-025 When reset=0, the block SHALL asynchronously force state IDLE, acc=0, busy=0, done=0, illegal=0, mem_wr_en=0 and mem_address=0, including mid-operation.
REQ-026 A reset during STORE SHALL deassert mem_wr_en combinationally within the same cycle.
REQ-027 After reset release, the first rising edge with enable=1 SHALL be accepted.

Configuration
REQ-028 With macro EXEC_UNIT_FLAGS_EN defined, the block SHALL add outputs carry (carry-out of the last ADD) and zero (acc==0), both updated in LOAD and reset to 0.
REQ-029 With EXEC_UNIT_FLAGS_EN defined, LD SHALL clear carry and update zero.
REQ-030 Without EXEC_UNIT_FLAGS_EN, the carry and zero ports and their logic SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-031 RAM[3]=2; LD 3 from reset -> mem_address=3 in FETCH_OP, acc=2, done 3 cycles after the accepting edge.
REQ-032 acc=2, RAM[4]=5; ADD 4 -> acc=7, no write; then STR 5 -> mem_wr_en high exactly one cycle, RAM[5]=7, done 2 cycles after the accepting edge.
REQ-033 acc=0xFF, RAM[4]=0x02; ADD 4 -> acc=0x01; with EXEC_UNIT_FLAGS_EN: carry=1, zero=0.
REQ-034 opcode 011, operand 7 -> illegal and done both high for one cycle, acc unchanged, mem_wr_en never high.
REQ-035 reset=0 asserted during FETCH_OP of LD 3 -> busy=0, acc=0 immediately; next LD 3 completes normally with acc=2.
REQ-036 enable held high through an ADD -> second operation accepted only in the cycle after done, never mid-operation.
